sd_cmd_sched: RTL and testbench

SD_CMD_SCHED -- requirements
Module: sd_cmd_sched

---
 rtl/sd_pkg.sv | 25 ++
 rtl/sd_rr_arb2.sv | 25 ++
 rtl/sd_cmd_sched.sv | 156 +++++++++++++++
 tb/tb_sd_cmd_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command scheduler: FSM state encoding,
// default timing constants and small helpers used by the scheduler slice.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_BUSY      = 3'd3,
    ST_RECOVER   = 3'd4
  } sd_state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 65535;
  localparam int unsigned RECOVER_CYC_DEF = 16;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that was not
// granted most recently wins; the pointer only moves when a grant is accepted.
module sd_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  // NOTE: asynchronous active-low reset; last=1 gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last <= 1'b1;
    else if (accept && gnt != 2'b00) last <= gnt[1];
  end

endmodule

// File: rtl/sd_cmd_sched.sv
// Command scheduler between two block-transfer requesters and one SD block
// engine: arbitration, engine handshake, timeout/abort, recovery and SD line mux.
module sd_cmd_sched
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF
) (
  input  logic        SD_clk,
  input  logic        rst_n,
  input  logic        init_done_i,
  input  logic        init_cs_i,
  input  logic        init_di_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic        eng_start_o,
  output logic        eng_we_o,
  output logic [31:0] eng_addr_o,
  output logic        eng_abort_o,
  input  logic        eng_done_i,
  input  logic        eng_err_i,
  input  logic        eng_cs_i,
  input  logic        eng_di_i,
  output logic        SD_cs,
  output logic        SD_datain,
  output logic        busy_o
);

  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYC);
  localparam int unsigned REC_W = cnt_width(RECOVER_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

  sd_state_t        state;
  logic             owner;
  logic [TMO_W-1:0] tmo_cnt;
  logic [REC_W-1:0] rec_cnt;
  logic [1:0]       arb_gnt;
  logic             arb_accept;

  assign arb_accept = (state == ST_IDLE) && init_done_i;

  sd_rr_arb2 u_arb (
    .clk    (SD_clk),
    .rst_n  (rst_n),
    .req    (req_i),
    .accept (arb_accept),
    .gnt    (arb_gnt)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_INIT;
      owner       <= 1'b0;
      tmo_cnt     <= '0;
      rec_cnt     <= '0;
      gnt_o       <= 2'b00;
      done_o      <= 2'b00;
      err_o       <= 2'b00;
      eng_start_o <= 1'b0;
      eng_abort_o <= 1'b0;
      eng_we_o    <= 1'b0;
      eng_addr_o  <= '0;
    end else begin
      gnt_o       <= 2'b00;
      done_o      <= 2'b00;
      err_o       <= 2'b00;
      eng_start_o <= 1'b0;
      eng_abort_o <= 1'b0;

      // Losing the initialised card overrides everything else.
      if (!init_done_i && state != ST_WAIT_INIT) begin
        state <= ST_WAIT_INIT;
        if (state == ST_START || state == ST_BUSY) begin
          eng_abort_o <= 1'b1;
          err_o       <= owner_mask(owner);
        end
      end else begin
        unique case (state)
          ST_WAIT_INIT: if (init_done_i) state <= ST_IDLE;

          ST_IDLE: if (arb_gnt != 2'b00) begin
            gnt_o       <= arb_gnt;
            owner       <= arb_gnt[1];
            eng_we_o    <= arb_gnt[1] ? we_i[1] : we_i[0];
            eng_addr_o  <= arb_gnt[1] ? addr1_i : addr0_i;
            eng_start_o <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_START;
          end

          ST_START: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            state   <= ST_BUSY;
          end

          // Completion takes precedence over a coincident timeout.
          ST_BUSY: begin
            if (eng_done_i) begin
              if (eng_err_i) begin
                err_o   <= owner_mask(owner);
                rec_cnt <= '0;
                state   <= ST_RECOVER;
              end else begin
                done_o <= owner_mask(owner);
                state  <= ST_IDLE;
              end
            end else if (tmo_cnt >= TMO_LAST) begin
              eng_abort_o <= 1'b1;
              err_o       <= owner_mask(owner);
              rec_cnt     <= '0;
              state       <= ST_RECOVER;
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          ST_RECOVER: begin
            if (rec_cnt >= REC_LAST) state <= ST_IDLE;
            else                     rec_cnt <= rec_cnt + 1'b1;
          end

          default: state <= ST_WAIT_INIT;
        endcase
      end
    end
  end

  // Card lines: zero-latency mux whose select is the registered state.
  always_comb begin
    SD_cs     = 1'b1;
    SD_datain = 1'b1;
    if (rst_n) begin
      case (state)
        ST_WAIT_INIT: begin
          SD_cs     = init_cs_i;
          SD_datain = init_di_i;
        end
        ST_START, ST_BUSY: begin
          SD_cs     = eng_cs_i;
          SD_datain = eng_di_i;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Self-checking bench for sd_cmd_sched: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_sd_cmd_sched;

  localparam int TMO = 32;
  localparam int REC = 16;

  logic        SD_clk = 1'b0;
  logic        rst_n;
  logic        init_done_i, init_cs_i, init_di_i;
  logic [1:0]  req_i, we_i;
  logic [31:0] addr0_i, addr1_i;
  logic [1:0]  gnt_o, done_o, err_o;
  logic        eng_start_o, eng_we_o, eng_abort_o;
  logic [31:0] eng_addr_o;
  logic        eng_done_i, eng_err_i, eng_cs_i, eng_di_i;
  logic        SD_cs, SD_datain, busy_o;

  int checks = 0;
  int errors = 0;
  int m_last = 1;

  sd_cmd_sched #(.TIMEOUT_CYC(TMO), .RECOVER_CYC(REC)) dut (
    .SD_clk      (SD_clk),
    .rst_n       (rst_n),
    .init_done_i (init_done_i),
    .init_cs_i   (init_cs_i),
    .init_di_i   (init_di_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .eng_start_o (eng_start_o),
    .eng_we_o    (eng_we_o),
    .eng_addr_o  (eng_addr_o),
    .eng_abort_o (eng_abort_o),
    .eng_done_i  (eng_done_i),
    .eng_err_i   (eng_err_i),
    .eng_cs_i    (eng_cs_i),
    .eng_di_i    (eng_di_i),
    .SD_cs       (SD_cs),
    .SD_datain   (SD_datain),
    .busy_o      (busy_o)
  );

  always #5 SD_clk = ~SD_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic drive_lines();
    init_cs_i = 1'($urandom);
    init_di_i = 1'($urandom);
    eng_cs_i  = 1'($urandom);
    eng_di_i  = 1'($urandom);
  endtask

  // Pulse outputs never name more than one requester.
  always @(negedge SD_clk) begin
    if (rst_n === 1'b1)
      check("onehot", {$onehot0(gnt_o), $onehot0(done_o), $onehot0(err_o)}, 3'b111);
  end

  // One transaction from an IDLE cycle; k = engine done cycle after start (0 = never).
  task automatic do_txn(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                        input logic [31:0] a1, input int k, input bit e);
    int w, res_cyc, last_cyc;
    bit is_err, is_abort, exp_busy;
    logic [1:0] m;
    logic [31:0] exp_addr;
    logic exp_we;
    if (req == 2'b11) w = (m_last == 1) ? 0 : 1;
    else              w = (req == 2'b10) ? 1 : 0;
    m_last   = w;
    m        = (w == 1) ? 2'b10 : 2'b01;
    exp_addr = (w == 1) ? a1 : a0;
    exp_we   = we[w];
    if (k != 0 && k <= TMO - 1) begin
      res_cyc = k + 1; is_err = e; is_abort = 1'b0;
    end else begin
      res_cyc = TMO; is_err = 1'b1; is_abort = 1'b1;
    end
    last_cyc = is_err ? res_cyc + REC : res_cyc;

    req_i = req; we_i = we; addr0_i = a0; addr1_i = a1;
    tick();
    req_i = 2'b00; we_i = 2'($urandom); addr0_i = $urandom; addr1_i = $urandom;
    drive_lines();
    #1;
    check("grant", {gnt_o, eng_start_o, busy_o, eng_we_o}, {m, 1'b1, 1'b1, exp_we});
    check("grant_addr", eng_addr_o, exp_addr);
    check("grant_lines", {SD_cs, SD_datain}, {eng_cs_i, eng_di_i});

    for (int c = 1; c <= last_cyc; c++) begin
      tick();
      eng_done_i = (c == k);
      eng_err_i  = (c == k) && e;
      drive_lines();
      #1;
      if (c < res_cyc) begin
        check("busy_cycle", {done_o, err_o, eng_abort_o, eng_start_o, busy_o, SD_cs, SD_datain},
              {4'b0000, 1'b0, 1'b0, 1'b1, eng_cs_i, eng_di_i});
      end else begin
        exp_busy = is_err && (c < res_cyc + REC);
        if (c == res_cyc) begin
          check("result", {done_o, err_o, eng_abort_o, eng_start_o, busy_o, SD_cs, SD_datain},
                {is_err ? 2'b00 : m, is_err ? m : 2'b00, is_abort, 1'b0, exp_busy, 2'b11});
          check("held_cmd", {eng_we_o, eng_addr_o}, {exp_we, exp_addr});
        end else begin
          check("recover", {done_o, err_o, eng_abort_o, eng_start_o, busy_o, SD_cs, SD_datain},
                {4'b0000, 1'b0, 1'b0, exp_busy, 2'b11});
        end
      end
    end
    eng_done_i = 1'b0;
    eng_err_i  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; init_done_i = 1'b0; init_cs_i = 1'b0; init_di_i = 1'b0;
    req_i = 2'b01; we_i = 2'b00; addr0_i = 32'h0000_1234; addr1_i = 32'h0000_5678;
    eng_done_i = 1'b0; eng_err_i = 1'b0; eng_cs_i = 1'b0; eng_di_i = 1'b0;

    // Reset state: card lines idle high whatever the init engine drives.
    #3;
    check("reset_out", {gnt_o, done_o, err_o, eng_start_o, eng_abort_o, busy_o, SD_cs, SD_datain, eng_we_o},
          {6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("reset_addr", eng_addr_o, 32'h0);
    repeat (2) @(posedge SD_clk);
    #2 rst_n = 1'b1;

    // Card not initialised: requests ignored, lines follow the init engine.
    for (int i = 0; i < 100; i++) begin
      tick();
      drive_lines();
      #1;
      check("wait_init", {gnt_o, SD_cs, SD_datain}, {2'b00, init_cs_i, init_di_i});
    end
    init_done_i = 1'b1;
    tick();
    check("idle_entry", {gnt_o, busy_o, SD_cs, SD_datain}, {2'b00, 1'b0, 2'b11});
    tick();
    check("first_grant", {gnt_o, eng_start_o, eng_addr_o}, {2'b01, 1'b1, 32'h0000_1234});
    m_last = 0;
    req_i = 2'b00;

    // Reset mid-transfer aborts silently.
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_reset", {err_o, done_o, eng_abort_o, SD_cs, SD_datain}, {4'b0000, 1'b0, 2'b11});
    check("mid_reset_addr", eng_addr_o, 32'h0);
    repeat (2) begin
      tick();
      check("in_reset", {err_o, eng_abort_o, SD_cs, SD_datain}, {2'b00, 1'b0, 2'b11});
    end
    rst_n = 1'b1;
    m_last = 1;
    tick();
    check("post_reset", {err_o, eng_abort_o, busy_o}, {2'b00, 1'b0, 1'b0});

    // Round robin on permanent contention: 0, 1, 0.
    do_txn(2'b11, 2'b00, 32'hA000_0000, 32'hB000_0000, 3, 1'b0);
    do_txn(2'b11, 2'b01, 32'hA000_0001, 32'hB000_0001, 4, 1'b0);
    do_txn(2'b11, 2'b10, 32'hA000_0002, 32'hB000_0002, 2, 1'b0);
    // Requester 1 block write.
    do_txn(2'b10, 2'b10, 32'h0000_0000, 32'h0000_0200, 6, 1'b0);
    // Timeout, then error coincident with timeout, then done coincident with timeout.
    do_txn(2'b01, 2'b01, 32'h0000_0040, 32'h0, 0, 1'b0);
    do_txn(2'b01, 2'b00, 32'h0000_0080, 32'h0, TMO - 1, 1'b1);
    do_txn(2'b10, 2'b00, 32'h0, 32'h0000_00C0, TMO - 1, 1'b0);
    // Engine error without timeout.
    do_txn(2'b01, 2'b11, 32'h0000_0100, 32'h0, 7, 1'b1);

    // Card lost during BUSY.
    req_i = 2'b01; addr0_i = 32'h0000_0300;
    tick();
    req_i = 2'b00;
    check("drop_grant", {gnt_o, eng_start_o}, {2'b01, 1'b1});
    m_last = 0;
    repeat (4) tick();
    init_done_i = 1'b0;
    tick();
    drive_lines();
    #1;
    check("drop_abort", {err_o, done_o, eng_abort_o, busy_o, SD_cs, SD_datain},
          {2'b01, 2'b00, 1'b1, 1'b1, init_cs_i, init_di_i});
    tick();
    drive_lines();
    #1;
    check("drop_wait", {err_o, eng_abort_o, SD_cs, SD_datain}, {2'b00, 1'b0, init_cs_i, init_di_i});
    init_done_i = 1'b1;
    tick();
    check("drop_idle", {busy_o, SD_cs, SD_datain}, {1'b0, 2'b11});

    // Randomized transactions against the model.
    for (int t = 0; t < 24; t++) begin
      int k;
      k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      do_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, k,
             ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
